// File: rtl/mult_seq_ctrl.sv
// Sequenced radix-2 shift-add multiplier with architectural HI/LO registers.
// Runs one partial-product step per cycle, then sign-corrects and commits.
module mult_seq_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              SIGNED,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              HI_WE,
  input  logic              LO_WE,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned MSB   = DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              neg;

  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [ACC_W-1:0]  addend;

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  always_comb begin
    mag_a  = (SIGNED && A[MSB]) ? (~A + 1'b1) : A;
    mag_b  = (SIGNED && B[MSB]) ? (~B + 1'b1) : B;
    addend = ACC_W'(mcand) << cnt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      HI     <= '0;
      LO     <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            neg    <= SIGNED & (A[MSB] ^ B[MSB]);
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= RUN;
          end else begin
            if (HI_WE) HI <= WDATA;
            if (LO_WE) LO <= WDATA;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= FIX;
        end
        FIX: begin
          {HI, LO} <= neg ? (~acc + 1'b1) : acc;
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corner cases plus random
// operations compared against a plain-arithmetic product and HI/LO model.
module tb_mult_seq_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  int unsigned  cyc      = 0;
  int unsigned  t0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_seq_ctrl #(.DATA_W(W)) dut (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(signed_op),
    .A(a), .B(b), .HI_WE(hi_we), .LO_WE(lo_we), .WDATA(wdata),
    .HI(hi), .LO(lo), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference product: both operands widened to 2W bits (sign- or
  // zero-extended), multiplied modulo 2^(2W).
  function automatic logic [63:0] ref_prod(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] xe, ye;
    xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    signed_op = s;
    a         = x;
    b         = y;
    start     = 1'b1;
    step();
    t0    = cyc;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] prod);
    int unsigned guard = 0;
    while (!done && guard < 100) begin
      step();
      guard++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, cyc - t0, W + 1);
    check({tag, "_busy_low"}, busy, 0);
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic idle_cycle(input string tag);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(s, x, y);
    wait_done(tag, ref_prod(s, x, y));
    idle_cycle(tag);
  endtask

  initial begin
    int unsigned seen_done;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    exp_hi = '0; exp_lo = '0;

    run_op("multu_5x20", 0, 32'd5, 32'd20);
    run_op("mult_m5x20", 1, -32'sd5, 32'd20);
    run_op("mult_m5xm20", 1, -32'sd5, -32'sd20);
    run_op("multu_4e9x2", 0, 32'd4000000000, 32'd2);
    run_op("mult_minxmin", 1, 32'h8000_0000, 32'h8000_0000);
    check("minxmin_hi_const", hi, 32'h4000_0000);

    // Back-to-back: reissue in the DONE cycle
    start_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", ref_prod(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    check("max_hi_const", hi, 32'hFFFF_FFFE);
    start_op(1, 32'd3, -32'sd7);
    wait_done("b2b", ref_prod(1, 32'd3, -32'sd7));
    idle_cycle("b2b");

    // START and HI_WE mid-run are ignored
    start_op(0, 32'd7, 32'd9);
    repeat (5) step();
    start = 1'b1; hi_we = 1'b1; wdata = 32'h1234; a = 32'd100; b = 32'd100;
    step();
    start = 1'b0; hi_we = 1'b0;
    check("midrun_hi_hold", hi, exp_hi);
    wait_done("midrun", ref_prod(0, 32'd7, 32'd9));
    idle_cycle("midrun");

    // Write both registers in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'hABCD; exp_lo = 32'hABCD;
    check("we_both_hi", hi, exp_hi);
    check("we_both_lo", lo, exp_lo);

    // START with writes in IDLE: writes dropped
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    start_op(1, 32'd11, 32'd13);
    hi_we = 1'b0; lo_we = 1'b0;
    check("start_wins_hi", hi, exp_hi);
    check("start_wins_lo", lo, exp_lo);
    wait_done("start_wins", ref_prod(1, 32'd11, 32'd13));
    idle_cycle("start_wins");

    // Reset mid-run aborts the operation
    start_op(0, 32'd123, 32'd456);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, exp_hi);
    check("abort_lo", lo, exp_lo);
    seen_done = 0;
    repeat (40) begin
      step();
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    // Randomized operations interleaved with single-register writes
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      bit s;
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 4 == 0) x = {1'b1, x[W-2:0]};
      run_op("rand", s, x, y);
      if ($urandom_range(0, 1) == 1) begin
        wdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          hi_we = 1'b1; exp_hi = wdata;
        end else begin
          lo_we = 1'b1; exp_lo = wdata;
        end
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        check("rand_we_hi", hi, exp_hi);
        check("rand_we_lo", lo, exp_lo);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
